// File: rtl/cpu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter_if
// Bundles every requester-side and memory-side signal of cpu_mem_arbiter.
//   slave  : arbiter view (requests and memory read data in; done/err,
//            read data and memory strobes out)
//   master : environment view (requesters plus memory array)
// Read channel i occupies rd_addr[i*ADDR_W +: ADDR_W] and rd_data[i*16 +: 16].
// ---------------------------------------------------------------------------
interface cpu_mem_arbiter_if #(
  parameter int NUM_RD = 2,
  parameter int ADDR_W = 16
);
  // read requesters
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD-1:0]        rd_size;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_done;
  logic [NUM_RD-1:0]        rd_err;
  logic [NUM_RD*16-1:0]     rd_data;
  // write requester
  logic                     wr_en;
  logic                     wr_size;
  logic [ADDR_W-1:0]        wr_addr;
  logic [15:0]              wr_data;
  logic                     wr_done;
  logic                     wr_err;
  // memory port
  logic                     mem_rd_en;
  logic [1:0]               mem_wr_en;
  logic [ADDR_W-2:0]        mem_addr;
  logic [15:0]              mem_wr_data;
  logic [15:0]              mem_rd_data;
  logic                     mem_rd_valid;

  modport slave (
    input  rd_en, rd_size, rd_addr, wr_en, wr_size, wr_addr, wr_data,
           mem_rd_data, mem_rd_valid,
    output rd_done, rd_err, rd_data, wr_done, wr_err,
           mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport master (
    output rd_en, rd_size, rd_addr, wr_en, wr_size, wr_addr, wr_data,
           mem_rd_data, mem_rd_valid,
    input  rd_done, rd_err, rd_data, wr_done, wr_err,
           mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// NUM_RD read channels and one write channel share a single 16-bit memory
// port. One transaction is in flight at a time; each ends with a one-cycle
// done pulse plus err flag on the granted channel only.
//
// Ports
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous reset, active low (0 = reset)
//   bus      : cpu_mem_arbiter_if.slave - requester handshakes, read data
//              and memory strobes/address/data
//
// Build option
//   CPU_MEM_ARB_WR_PRIORITY_EN : when defined, a pending write always wins
//   and the round-robin pointer rotates over the read channels only. When
//   undefined, round-robin runs over NUM_RD+1 slots (write = slot NUM_RD).
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter int NUM_RD    = 2,
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 32768,
  parameter int TIMEOUT   = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  cpu_mem_arbiter_if.slave bus
);

  localparam int                NSLOT      = NUM_RD + 1;
  localparam int                SLOT_W     = $clog2(NSLOT);
  localparam logic [SLOT_W-1:0] WR_SLOT    = SLOT_W'(NUM_RD);
  localparam logic [63:0]       ADDR_LIMIT = 64'(2 * longint'(MEM_WORDS));
  localparam logic [7:0]        CNT_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Byte writes hit one lane, chosen by the address LSB.
  function automatic logic [1:0] wr_lanes(input logic size, input logic lane);
    if (size) return 2'b11;
    return lane ? 2'b10 : 2'b01;
  endfunction

  // Byte reads return the addressed lane zero-extended.
  function automatic logic [15:0] rd_format(input logic size, input logic lane,
                                            input logic [15:0] d);
    if (size) return d;
    return lane ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
  endfunction

  state_t               r_state;
  state_t               w_next;
  logic [SLOT_W-1:0]    r_ptr;
  logic [SLOT_W-1:0]    r_slot;
  logic                 r_err;
  logic [7:0]           r_cnt;
  logic [NUM_RD*16-1:0] r_rd_data;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_size;
  logic [15:0]          r_wdata;

  logic [NSLOT-1:0]     w_req;
  logic                 w_gnt_vld;
  logic [SLOT_W-1:0]    w_gnt_slot;
  logic [SLOT_W-1:0]    w_ptr_next;
  logic [ADDR_W-1:0]    w_g_addr;
  logic                 w_g_size;
  logic                 w_g_bad;
  logic                 w_is_wr;
  logic [NUM_RD-1:0]    w_rd_done;
  logic                 w_wr_done;
  logic                 w_mem_rd_en;
  logic [1:0]           w_mem_wr_en;
  logic [ADDR_W-2:0]    w_mem_addr;
  logic [15:0]          w_mem_wr_data;

  assign w_req   = {bus.wr_en, bus.rd_en};
  assign w_is_wr = (r_slot == WR_SLOT);

  // Round-robin search starting at the pointer; the first requester wins.
  always_comb begin
    int s;
    s          = 0;
    w_gnt_vld  = 1'b0;
    w_gnt_slot = '0;
    w_ptr_next = r_ptr;
`ifdef CPU_MEM_ARB_WR_PRIORITY_EN
    if (bus.wr_en) begin
      // Write grant leaves the read rotation untouched.
      w_gnt_vld  = 1'b1;
      w_gnt_slot = WR_SLOT;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        s = (int'(r_ptr) + i) % NUM_RD;
        if (!w_gnt_vld && bus.rd_en[s]) begin
          w_gnt_vld  = 1'b1;
          w_gnt_slot = SLOT_W'(s);
          w_ptr_next = SLOT_W'((s + 1) % NUM_RD);
        end
      end
    end
`else
    for (int i = 0; i < NSLOT; i++) begin
      s = (int'(r_ptr) + i) % NSLOT;
      if (!w_gnt_vld && w_req[s]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_slot = SLOT_W'(s);
        w_ptr_next = SLOT_W'((s + 1) % NSLOT);
      end
    end
`endif
  end

  // Fetch the winner's address/size and validate before anything is issued.
  always_comb begin
    w_g_addr = bus.wr_addr;
    w_g_size = bus.wr_size;
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_gnt_slot == SLOT_W'(i)) begin
        w_g_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
        w_g_size = bus.rd_size[i];
      end
    end
    w_g_bad = (w_g_size & w_g_addr[0]) | (64'(w_g_addr) >= ADDR_LIMIT);
  end

  // Next state and outputs, all decoded from the registered state.
  always_comb begin
    w_next        = r_state;
    w_rd_done     = '0;
    w_wr_done     = 1'b0;
    w_mem_rd_en   = 1'b0;
    w_mem_wr_en   = 2'b00;
    w_mem_addr    = '0;
    w_mem_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) w_next = w_g_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        w_mem_addr = r_addr[ADDR_W-1:1];
        if (w_is_wr) begin
          w_mem_wr_en   = wr_lanes(r_size, r_addr[0]);
          w_mem_wr_data = r_wdata;
          w_next        = S_RESP;
        end else begin
          w_mem_rd_en = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rd_valid || (r_cnt == CNT_LAST)) w_next = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < NUM_RD; i++) w_rd_done[i] = (r_slot == SLOT_W'(i));
        w_wr_done = w_is_wr;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control state: FSM, pointer, grant, error flag, timeout count, read data.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_slot    <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_gnt_vld) begin
        r_ptr  <= w_ptr_next;
        r_slot <= w_gnt_slot;
        r_err  <= w_g_bad;
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
        if (bus.mem_rd_valid) begin
          for (int i = 0; i < NUM_RD; i++) begin
            if (r_slot == SLOT_W'(i))
              r_rd_data[i*16 +: 16] <= rd_format(r_size, r_addr[0], bus.mem_rd_data);
          end
        end else if (r_cnt == CNT_LAST) begin
          r_err <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Request payload is only observed while its transaction is active.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_IDLE) && w_gnt_vld) begin
      r_addr  <= w_g_addr;
      r_size  <= w_g_size;
      r_wdata <= w_g_size ? bus.wr_data : {bus.wr_data[7:0], bus.wr_data[7:0]};
    end
  end

  assign bus.rd_done     = w_rd_done;
  assign bus.rd_err      = w_rd_done & {NUM_RD{r_err}};
  assign bus.rd_data     = r_rd_data;
  assign bus.wr_done     = w_wr_done;
  assign bus.wr_err      = w_wr_done & r_err;
  assign bus.mem_rd_en   = w_mem_rd_en;
  assign bus.mem_wr_en   = w_mem_wr_en;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wr_data = w_mem_wr_data;

endmodule
